// File: rtl/lv_param.sv
// Shared types and helpers for the LV one-wire transaction scheduler.
// FSM states, frame owner enum and counter width helper.
package lv_param;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARB     = 3'd1,
      ST_SEND    = 3'd2,
      ST_WAIT_TX = 3'd3,
      ST_WAIT_RX = 3'd4,
      ST_DONE    = 3'd5,
      ST_GAP     = 3'd6
   } state_t;

   typedef enum logic {
      SRC_REG = 1'b0,
      SRC_ADC = 1'b1
   } src_t;

   localparam int CMD_W_DEF     = 8;
   localparam int DATA_W_DEF    = 16;
   localparam int POLL_CYC_DEF  = 2000;
   localparam int GAP_CYC_DEF   = 16;
   localparam int RETRY_MAX_DEF = 2;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n < 3) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lv_owt_rr_arb2.sv
// Two-way round-robin arbiter between register port and ADC poll.
// Pointer only moves when both sources contend, toward the loser.
module lv_owt_rr_arb2
   import lv_param::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_req_reg,
   input  logic i_req_adc,
   input  logic i_take,
   output logic o_vld,
   output src_t o_gnt
);

   src_t ptr_q;
   src_t ptr_d;
   logic both;

   // Grant selection and pointer update for the next contention.
   always_comb begin
      both  = i_req_reg & i_req_adc;
      o_vld = i_req_reg | i_req_adc;
      if (both) begin
         o_gnt = ptr_q;
      end else if (i_req_reg) begin
         o_gnt = SRC_REG;
      end else begin
         o_gnt = SRC_ADC;
      end
      ptr_d = ptr_q;
      if (i_take && both) begin
         ptr_d = (o_gnt == SRC_REG) ? SRC_ADC : SRC_REG;
      end
   end

   // Pointer register, starts favouring the register port.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_q <= SRC_REG;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/lv_owt_txn_sched.sv
// LV-side one-wire transaction scheduler: arbitrates register and
// ADC-poll traffic onto one OWT link, one frame in flight, with retry.
module lv_owt_txn_sched
   import lv_param::*;
#(
   parameter int               CMD_W     = CMD_W_DEF,
   parameter int               DATA_W    = DATA_W_DEF,
   parameter logic [CMD_W-1:0] ADC_CMD   = CMD_W'(8'h1f),
   parameter int               POLL_CYC  = POLL_CYC_DEF,
   parameter int               GAP_CYC   = GAP_CYC_DEF,
   parameter int               RETRY_MAX = RETRY_MAX_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_reg_req,
   input  logic [CMD_W-1:0]  i_reg_cmd,
   input  logic [DATA_W-1:0] i_reg_wdata,
   output logic              o_reg_ack,
   output logic [DATA_W-1:0] o_reg_rdata,
   output logic              o_reg_err,
   input  logic              i_adc_poll_en,
   output logic              o_adc_vld,
   output logic [DATA_W-1:0] o_adc_data,
   output logic              o_adc_err,
   output logic              o_owt_tx_req,
   output logic [CMD_W-1:0]  o_owt_tx_cmd,
   output logic [DATA_W-1:0] o_owt_tx_data,
   input  logic              i_owt_tx_done,
   output logic [CMD_W-1:0]  o_owt_tx_cmd_lock,
   input  logic              i_owt_rx_ack,
   input  logic              i_owt_rx_status,
   input  logic [DATA_W-1:0] i_owt_rx_data,
   output logic              o_busy
);

   localparam int POLL_W = cnt_w(POLL_CYC);
   localparam int GAP_W  = cnt_w(GAP_CYC);
   localparam int RTY_W  = cnt_w(RETRY_MAX + 1);

   localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYC - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
   localparam logic [RTY_W-1:0]  RTY_LAST  = RTY_W'(RETRY_MAX);

   state_t             state_q, state_d;
   src_t               src_q, src_d;
   logic [RTY_W-1:0]   retry_q, retry_d;
   logic               rty_pend_q, rty_pend_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [POLL_W-1:0]  tmr_q, tmr_d;
   logic               poll_pend_q, poll_pend_d;
   logic               tx_req_q, tx_req_d;
   logic [CMD_W-1:0]   tx_cmd_q, tx_cmd_d;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;
   logic [CMD_W-1:0]   cmd_lock_q, cmd_lock_d;
   logic               reg_ack_q, reg_ack_d;
   logic [DATA_W-1:0]  reg_rdata_q, reg_rdata_d;
   logic               reg_err_q, reg_err_d;
   logic               adc_vld_q, adc_vld_d;
   logic [DATA_W-1:0]  adc_data_q, adc_data_d;
   logic               adc_err_q, adc_err_d;
   logic               busy_q, busy_d;

   logic arb_vld;
   logic arb_take;
   src_t arb_gnt;

   lv_owt_rr_arb2 u_arb (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_req_reg (i_reg_req),
      .i_req_adc (poll_pend_q),
      .i_take    (arb_take),
      .o_vld     (arb_vld),
      .o_gnt     (arb_gnt)
   );

   // Poll timer, frame sequencing and owner result reporting.
   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      retry_d     = retry_q;
      rty_pend_d  = rty_pend_q;
      gap_cnt_d   = gap_cnt_q;
      tmr_d       = tmr_q;
      poll_pend_d = poll_pend_q;
      tx_req_d    = 1'b0;
      tx_cmd_d    = tx_cmd_q;
      tx_data_d   = tx_data_q;
      cmd_lock_d  = cmd_lock_q;
      reg_ack_d   = 1'b0;
      reg_rdata_d = reg_rdata_q;
      reg_err_d   = reg_err_q;
      adc_vld_d   = 1'b0;
      adc_data_d  = adc_data_q;
      adc_err_d   = adc_err_q;
      arb_take    = 1'b0;

      if (!i_adc_poll_en) begin
         tmr_d       = '0;
         poll_pend_d = 1'b0;
      end else if (tmr_q == POLL_LAST) begin
         tmr_d       = '0;
         poll_pend_d = 1'b1;
      end else begin
         tmr_d = tmr_q + POLL_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (i_reg_req | poll_pend_q) begin
               state_d = ST_ARB;
            end
         end
         ST_ARB: begin
            if (arb_vld) begin
               arb_take = 1'b1;
               src_d    = arb_gnt;
               if (arb_gnt == SRC_ADC) begin
                  tx_cmd_d    = ADC_CMD;
                  tx_data_d   = '0;
                  poll_pend_d = 1'b0;
               end else begin
                  tx_cmd_d  = i_reg_cmd;
                  tx_data_d = i_reg_wdata;
               end
               cmd_lock_d = tx_cmd_d;
               tx_req_d   = 1'b1;
               state_d    = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            state_d = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (i_owt_tx_done) begin
               state_d = ST_WAIT_RX;
            end
         end
         ST_WAIT_RX: begin
            if (i_owt_rx_ack) begin
               if (i_owt_rx_status && (retry_q < RTY_LAST)) begin
                  retry_d    = retry_q + RTY_W'(1);
                  rty_pend_d = 1'b1;
                  gap_cnt_d  = '0;
                  state_d    = ST_GAP;
               end else begin
                  state_d = ST_DONE;
                  if (src_q == SRC_REG) begin
                     reg_ack_d   = 1'b1;
                     reg_rdata_d = i_owt_rx_data;
                     reg_err_d   = i_owt_rx_status;
                  end else begin
                     adc_vld_d = 1'b1;
                     adc_err_d = i_owt_rx_status;
                     if (!i_owt_rx_status) begin
                        adc_data_d = i_owt_rx_data;
                     end
                  end
               end
            end
         end
         ST_DONE: begin
            retry_d    = '0;
            rty_pend_d = 1'b0;
            gap_cnt_d  = '0;
            state_d    = ST_GAP;
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               if (rty_pend_q) begin
                  rty_pend_d = 1'b0;
                  tx_req_d   = 1'b1;
                  state_d    = ST_SEND;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // All state and registered outputs; async reset aborts any frame.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         src_q       <= SRC_REG;
         retry_q     <= '0;
         rty_pend_q  <= 1'b0;
         gap_cnt_q   <= '0;
         tmr_q       <= '0;
         poll_pend_q <= 1'b0;
         tx_req_q    <= 1'b0;
         tx_cmd_q    <= '0;
         tx_data_q   <= '0;
         cmd_lock_q  <= '0;
         reg_ack_q   <= 1'b0;
         reg_rdata_q <= '0;
         reg_err_q   <= 1'b0;
         adc_vld_q   <= 1'b0;
         adc_data_q  <= '0;
         adc_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         retry_q     <= retry_d;
         rty_pend_q  <= rty_pend_d;
         gap_cnt_q   <= gap_cnt_d;
         tmr_q       <= tmr_d;
         poll_pend_q <= poll_pend_d;
         tx_req_q    <= tx_req_d;
         tx_cmd_q    <= tx_cmd_d;
         tx_data_q   <= tx_data_d;
         cmd_lock_q  <= cmd_lock_d;
         reg_ack_q   <= reg_ack_d;
         reg_rdata_q <= reg_rdata_d;
         reg_err_q   <= reg_err_d;
         adc_vld_q   <= adc_vld_d;
         adc_data_q  <= adc_data_d;
         adc_err_q   <= adc_err_d;
         busy_q      <= busy_d;
      end
   end

   assign o_reg_ack         = reg_ack_q;
   assign o_reg_rdata       = reg_rdata_q;
   assign o_reg_err         = reg_err_q;
   assign o_adc_vld         = adc_vld_q;
   assign o_adc_data        = adc_data_q;
   assign o_adc_err         = adc_err_q;
   assign o_owt_tx_req      = tx_req_q;
   assign o_owt_tx_cmd      = tx_cmd_q;
   assign o_owt_tx_data     = tx_data_q;
   assign o_owt_tx_cmd_lock = cmd_lock_q;
   assign o_busy            = busy_q;

endmodule
